hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the combined ARM/RISC-V five-stage core. Drives the stall, flush and forwarding controls consumed by the fetch/decode/execute stage registers. Sequences the multi-cycle ISA-mode switch (drain, switch, resume) and owns the architectural mode bit `armMode`. Also keeps a saturating stall-cycle performance counter.

## Interface
- `DRAIN_CYCLES`, default 3: bubble cycles inserted before a mode switch (legal range 1..15).
- `RESET_ARM`, default 0: value of `armMode` after reset (0 = RISC-V, 1 = ARM).
- `clk` in 1: core clock.
- `rst` in 1: reset, asynchronous, active-high.
- `Rs1D`, `Rs2D` in 5: source registers of the instruction in D.
- `Rs1E`, `Rs2E`, `RdE` in 5: source and destination registers of the instruction in E.
- `RdM`, `RdW` in 5: destination registers in M and W.
- `RegWriteM`, `RegWriteW` in 1: register-write enables in M and W.
- `LoadE` in 1: the instruction in E is a memory load (`ResultSrcE == 01`).
- `PCSrcE` in 1: branch taken, resolved in E.
- `uStallD` in 1: LDM micro-op sequencer requests that D hold.
- `SwitchReqD` in 1: the instruction in D is an ISA-switch marker.
- `StallF`, `StallD` out 1: hold the F and D pipeline registers.
- `FlushD`, `FlushE` out 1: clear the D and E pipeline registers.
- `FwdAE`, `FwdBE` out 2: operand forward select for E. 00 = register file, 01 = W result, 10 = M ALU result.
- `armMode` out 1: current ISA mode, registered.
- `busy` out 1: a mode switch is in progress (state is not RUN).
- `stallCnt` out 16: saturating count of cycles with `StallD` = 1.

## Operation
- Register-match rule `match(a,b)`: `a == b`. In RISC-V mode (`armMode` = 0) the match also requires `a != 0`. In ARM mode, index 15 never matches, because r15 reads return PC+8.
- Forwarding, combinational, shown for A (B is identical using `Rs2E`):
  - `FwdAE` = 10 if `RegWriteM & match(RdM, Rs1E)`;
  - else 01 if `RegWriteW & match(RdW, Rs1E)`;
  - else 00.
  - M has priority over W.
- Load-use: `lwStall = LoadE & (match(RdE,Rs1D) | match(RdE,Rs2D))`.
- FSM states:
  - RUN:
    - `StallF = StallD = lwStall | uStallD`.
    - `FlushE = lwStall | PCSrcE`.
    - `FlushD = PCSrcE`.
    - If `SwitchReqD & ~PCSrcE & ~lwStall & ~uStallD`: go to DRAIN and load `drainCnt` = `DRAIN_CYCLES-1`.
  - DRAIN:
    - `StallF = StallD = 1`, `FlushE = 1`, `FlushD = 0`.
    - Decrement `drainCnt`; when it is 0, go to SWITCH.
  - SWITCH (exactly 1 cycle):
    - `StallF = StallD = 0`, `FlushD = 1` (discards the marker), `FlushE = 1`.
    - `armMode` toggles at the clock edge leaving SWITCH.
    - Next state is RUN.
- `PCSrcE` = 1 in DRAIN or SWITCH: abort to RUN without toggling `armMode`, with `FlushD = FlushE = 1` and `StallF = StallD = 0` that cycle.
- `stallCnt` increments when `StallD` = 1 and saturates at 0xFFFF.
- `drainCnt` is 4 bits.

## Timing
- Reset values: state RUN, `armMode` = `RESET_ARM`, `drainCnt` = 0, `stallCnt` = 0, `busy` = 0. All other outputs are the RUN-state combinational values.
- `FwdAE/BE`, `lwStall`, stall and flush outputs are combinational from inputs and state (zero-cycle latency).
- A mode switch occupies `DRAIN_CYCLES` + 1 cycles after the request cycle. The new mode is visible on `armMode` in the following cycle.
- Priority, high to low:
  1. `rst`
  2. `PCSrcE`
  3. `lwStall` / `uStallD`
  4. `SwitchReqD`
- `rst` asserted mid-switch returns to RUN immediately and asynchronously, with `armMode` = `RESET_ARM`.

## Test plan
- RISC-V mode: `RdM` = 5, `RegWriteM` = 1, `Rs1E` = 5, plus `RdW` = 5, `RegWriteW` = 1 -> `FwdAE` = 10. With `RdM` = `RdW` = 0 -> `FwdAE` = 00. In ARM mode, `RdM` = 0 -> 10, and `RdM` = 15 -> 00.
- `LoadE` = 1, `RdE` = 7, `Rs2D` = 7 -> `StallF` = `StallD` = `FlushE` = 1 for one cycle, and `stallCnt` increments by 1.
- `SwitchReqD` = 1 with `DRAIN_CYCLES` = 3:
  - `busy` = 1 for 4 cycles;
  - `StallD` = 1 for 3 cycles, then `FlushD` = 1 for 1 cycle;
  - `armMode` flips 0 -> 1.
- `PCSrcE` = 1 during the second DRAIN cycle -> RUN next cycle, `FlushD` = `FlushE` = 1, `armMode` unchanged.
- `SwitchReqD` together with `PCSrcE` -> no switch. `rst` pulse mid-DRAIN -> `busy` = 0 and `armMode` = `RESET_ARM` without waiting for a clock edge.
- Force 70000 consecutive stall cycles -> `stallCnt` = 0xFFFF and holds.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the dual-ISA five-stage core: forwarding,
// load-use stalls, branch flushes, and the drain/switch/resume ISA-mode sequence.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter bit RESET_ARM    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        LoadE,
  input  logic        PCSrcE,
  input  logic        uStallD,
  input  logic        SwitchReqD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  FwdAE,
  output logic [1:0]  FwdBE,
  output logic        armMode,
  output logic        busy,
  output logic [15:0] stallCnt
);

  typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic        arm_mode_q, arm_mode_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        lw_stall;

  // x0 is hardwired zero in RISC-V; r15 reads PC+8 in ARM, so neither forwards.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b,
                                     input logic arm);
    return (a == b) && (arm ? (a != 5'd15) : (a != 5'd0));
  endfunction

  assign lw_stall = LoadE & (reg_match(RdE, Rs1D, arm_mode_q) |
                             reg_match(RdE, Rs2D, arm_mode_q));

  always_comb begin
    FwdAE = 2'b00;
    FwdBE = 2'b00;
    if (RegWriteM && reg_match(RdM, Rs1E, arm_mode_q))      FwdAE = 2'b10;
    else if (RegWriteW && reg_match(RdW, Rs1E, arm_mode_q)) FwdAE = 2'b01;
    if (RegWriteM && reg_match(RdM, Rs2E, arm_mode_q))      FwdBE = 2'b10;
    else if (RegWriteW && reg_match(RdW, Rs2E, arm_mode_q)) FwdBE = 2'b01;
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    arm_mode_d  = arm_mode_q;
    StallF      = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    case (state_q)
      RUN: begin
        StallF = lw_stall | uStallD;
        StallD = lw_stall | uStallD;
        FlushE = lw_stall | PCSrcE;
        FlushD = PCSrcE;
        if (SwitchReqD && !PCSrcE && !lw_stall && !uStallD) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_INIT;
        end
      end
      DRAIN: begin
        FlushE = 1'b1;
        if (PCSrcE) begin
          FlushD  = 1'b1;
          state_d = RUN;
        end else begin
          StallF = 1'b1;
          StallD = 1'b1;
          if (drain_cnt_q == 4'd0) state_d = SWITCH;
          else                     drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      SWITCH: begin
        FlushD  = 1'b1;
        FlushE  = 1'b1;
        state_d = RUN;
        // A branch resolving in the switch cycle cancels the mode change.
        if (!PCSrcE) arm_mode_d = ~arm_mode_q;
      end
      default: state_d = RUN;
    endcase
    stall_cnt_d = (StallD && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      drain_cnt_q <= 4'd0;
      arm_mode_q  <= RESET_ARM;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      arm_mode_q  <= arm_mode_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign armMode  = arm_mode_q;
  assign busy     = (state_q != RUN);
  assign stallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a behavioural model that
// tracks the mode switch as a remaining-cycle countdown.
module tb_hazard_ctrl;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, LoadE, PCSrcE, uStallD, SwitchReqD;
  logic StallF, StallD, FlushD, FlushE, armMode, busy;
  logic [1:0] FwdAE, FwdBE;
  logic [15:0] stallCnt;

  int checks = 0;
  int errors = 0;

  // model state
  bit m_arm;
  int m_left;   // cycles of the switch sequence still to run (0 = normal)
  int m_cnt;

  hazard_ctrl #(.DRAIN_CYCLES(D), .RESET_ARM(1'b0)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .uStallD(uStallD), .SwitchReqD(SwitchReqD),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .FwdAE(FwdAE), .FwdBE(FwdBE), .armMode(armMode), .busy(busy), .stallCnt(stallCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit mm(input logic [4:0] a, input logic [4:0] b);
    if (a != b) return 1'b0;
    return m_arm ? (a != 5'd15) : (a != 5'd0);
  endfunction

  function automatic int fwd(input logic [4:0] rs);
    if (RegWriteM && mm(RdM, rs)) return 2;
    if (RegWriteW && mm(RdW, rs)) return 1;
    return 0;
  endfunction

  function automatic bit m_lw();
    return LoadE && (mm(RdE, Rs1D) || mm(RdE, Rs2D));
  endfunction

  // expected {stall, flushD, flushE}
  function automatic logic [2:0] m_ctl();
    if (m_left == 0)  return {m_lw() | uStallD, PCSrcE, m_lw() | PCSrcE};
    if (PCSrcE)       return 3'b011;
    if (m_left > 1)   return 3'b101;
    return 3'b011;
  endfunction

  task automatic model_reset();
    m_arm = 1'b0; m_left = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [2:0] c;
    if (rst) begin model_reset(); return; end
    c = m_ctl();
    if (c[2] && m_cnt < 65535) m_cnt++;
    if (m_left == 0) begin
      if (SwitchReqD && !PCSrcE && !m_lw() && !uStallD) m_left = D + 1;
    end else if (PCSrcE) m_left = 0;
    else begin
      if (m_left == 1) m_arm = !m_arm;
      m_left--;
    end
  endtask

  task automatic compare_all();
    logic [2:0] c;
    c = m_ctl();
    chk("StallF", StallF, c[2]);
    chk("StallD", StallD, c[2]);
    chk("FlushD", FlushD, c[1]);
    chk("FlushE", FlushE, c[0]);
    chk("FwdAE", FwdAE, fwd(Rs1E));
    chk("FwdBE", FwdBE, fwd(Rs2E));
    chk("armMode", armMode, m_arm);
    chk("busy", busy, m_left != 0);
    chk("stallCnt", stallCnt, m_cnt);
  endtask

  // inputs must already be applied; returns 1 time unit after the next posedge
  task automatic tick();
    @(negedge clk); compare_all();
    @(posedge clk); model_step();
    #1;
  endtask

  task automatic idle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, LoadE, PCSrcE, uStallD, SwitchReqD} = '0;
  endtask

  function automatic logic [4:0] pick();
    return ($urandom_range(0, 3) == 0) ? 5'd15 : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_arm", armMode, 0);
    chk("reset_cnt", stallCnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // RISC-V forwarding
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    #1 chk("rv_fwd_m", FwdAE, 2'b10);
    tick();
    Rs1E = 0; RdM = 0; RdW = 0;
    #1 chk("rv_fwd_x0", FwdAE, 2'b00);
    tick();
    idle();

    // load-use
    LoadE = 1; RdE = 7; Rs2D = 7;
    #1 chk("lu_stall", {StallF, StallD, FlushE}, 3'b111);
    tick();
    idle();
    #1 chk("lu_cnt", stallCnt, 1);
    chk("lu_clear", StallD, 0);

    // full mode switch
    SwitchReqD = 1;
    tick();
    SwitchReqD = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sw_busy", busy, 1);
      chk("sw_stall", StallD, i < 3);
      chk("sw_flushD", FlushD, i == 3);
      tick();
    end
    #1 chk("sw_done", busy, 0);
    chk("sw_arm", armMode, 1);
    chk("sw_cnt", stallCnt, 4);

    // ARM-mode forwarding
    RegWriteM = 1; RdM = 0; Rs1E = 0;
    #1 chk("arm_fwd_r0", FwdAE, 2'b10);
    tick();
    RdM = 15; Rs1E = 15;
    #1 chk("arm_fwd_r15", FwdAE, 2'b00);
    tick();
    idle();

    // branch abort in second DRAIN cycle
    SwitchReqD = 1;
    tick();
    SwitchReqD = 0;
    tick();
    PCSrcE = 1;
    #1 chk("abort_ctl", {StallD, FlushD, FlushE}, 3'b011);
    tick();
    PCSrcE = 0;
    #1 chk("abort_busy", busy, 0);
    chk("abort_arm", armMode, 1);

    // switch request with a taken branch is ignored
    SwitchReqD = 1; PCSrcE = 1;
    tick();
    idle();
    #1 chk("sw_pc_busy", busy, 0);

    // async reset mid-DRAIN
    SwitchReqD = 1;
    tick();
    SwitchReqD = 0;
    tick();
    chk("drain_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_arm", armMode, 0);
    model_reset();
    tick();
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Rs1D = pick(); Rs2D = pick(); Rs1E = pick(); Rs2E = pick();
      RdE = pick(); RdM = pick(); RdW = pick();
      RegWriteM = ($urandom_range(0, 1) == 1);
      RegWriteW = ($urandom_range(0, 1) == 1);
      LoadE = ($urandom_range(0, 9) < 3);
      PCSrcE = ($urandom_range(0, 9) == 0);
      uStallD = ($urandom_range(0, 9) == 0);
      SwitchReqD = ($urandom_range(0, 4) == 0);
      tick();
    end
    idle();
    repeat (D + 2) tick();

    // saturation
    uStallD = 1;
    for (int i = 0; i < 70000; i++) tick();
    chk("sat_cnt", stallCnt, 16'hFFFF);
    repeat (5) tick();
    chk("sat_hold", stallCnt, 16'hFFFF);
    uStallD = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
